// File: rtl/btb_if.sv
// Lookup/update port bundle for the branch target buffer.
interface btb_if;
    logic [31:0] lookup_pc;
    logic        btb_predicted;
    logic [31:0] btb_predicted_address;
    logic        update_valid;
    logic [31:0] update_pc;
    logic [31:0] update_target;
    logic        update_taken;

    modport master (
        output lookup_pc, update_valid, update_pc, update_target, update_taken,
        input  btb_predicted, btb_predicted_address
    );

    modport slave (
        input  lookup_pc, update_valid, update_pc, update_target, update_taken,
        output btb_predicted, btb_predicted_address
    );
endinterface

// File: rtl/btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BTB_BYPASS_EN to forward a same-cycle update of the looked-up entry to the outputs.
module btb #(
    parameter int unsigned ENTRIES = 16
) (
    input logic  Clk,
    input logic  Reset,
    btb_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];

    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;

    assign lk_idx  = bus.lookup_pc[IDX_W+1:2];
    assign lk_tag  = bus.lookup_pc[31:IDX_W+2];
    assign upd_idx = bus.update_pc[IDX_W+1:2];
    assign upd_tag = bus.update_pc[31:IDX_W+2];

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.update_pc[1:0]};

    logic             upd_hit;
    logic             upd_we;
    logic             nxt_valid;
    logic [TAG_W-1:0] nxt_tag;
    logic [31:0]      nxt_target;
    logic [1:0]       nxt_ctr;

    // Post-update contents of the entry addressed by update_pc.
    always_comb begin
        upd_hit    = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        nxt_valid  = valid_q[upd_idx];
        nxt_tag    = tag_q[upd_idx];
        nxt_target = target_q[upd_idx];
        nxt_ctr    = ctr_q[upd_idx];
        if (upd_hit) begin
            if (bus.update_taken) begin
                nxt_target = bus.update_target;
                if (ctr_q[upd_idx] != 2'd3) nxt_ctr = ctr_q[upd_idx] + 2'd1;
            end else begin
                if (ctr_q[upd_idx] != 2'd0) nxt_ctr = ctr_q[upd_idx] - 2'd1;
            end
        end else if (bus.update_taken) begin
            nxt_valid  = 1'b1;
            nxt_tag    = upd_tag;
            nxt_target = bus.update_target;
            nxt_ctr    = 2'd2;
        end
    end

    // A not-taken miss leaves the entry alone, so it never needs a write.
    assign upd_we = bus.update_valid && !Reset && (upd_hit || bus.update_taken);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                valid_q[IDX_W'(i)] <= 1'b0;
                ctr_q[IDX_W'(i)]   <= 2'd1;
            end
        end else if (upd_we) begin
            valid_q[upd_idx]  <= nxt_valid;
            tag_q[upd_idx]    <= nxt_tag;
            target_q[upd_idx] <= nxt_target;
            ctr_q[upd_idx]    <= nxt_ctr;
        end
    end

    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    logic [31:0]      rd_target;
    logic [1:0]       rd_ctr;
    logic             lk_hit;

    always_comb begin
        rd_valid  = valid_q[lk_idx];
        rd_tag    = tag_q[lk_idx];
        rd_target = target_q[lk_idx];
        rd_ctr    = ctr_q[lk_idx];
`ifdef BTB_BYPASS_EN
        if (upd_we && (upd_idx == lk_idx)) begin
            rd_valid  = nxt_valid;
            rd_tag    = nxt_tag;
            rd_target = nxt_target;
            rd_ctr    = nxt_ctr;
        end
`else
`endif
        lk_hit                    = rd_valid && (rd_tag == lk_tag);
        bus.btb_predicted         = lk_hit && rd_ctr[1];
        bus.btb_predicted_address = bus.btb_predicted ? rd_target : 32'h0;
    end
endmodule

// File: tb/tb_btb.sv
// Randomized bench for btb against a table-of-entries reference model.
module tb_btb;
    localparam int N = 16;

    typedef struct {
        logic [31:0] tag;
        logic [31:0] target;
        int          ctr;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t mdl[int];

    btb_if bus ();

    btb #(.ENTRIES(N)) dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * N);
    endfunction

    function automatic bit m_pred(input bit present, input ent_t e, input logic [31:0] pc);
        return present && (e.tag == tag_of(pc)) && (e.ctr >= 2);
    endfunction

    function automatic void m_next(input bit present, input ent_t e, input logic [31:0] pc,
                                   input logic [31:0] tgt, input bit tk,
                                   output bit np, output ent_t ne);
        np = present;
        ne = e;
        if (present && e.tag == tag_of(pc)) begin
            if (tk) begin
                ne.ctr    = (e.ctr == 3) ? 3 : e.ctr + 1;
                ne.target = tgt;
            end else begin
                ne.ctr = (e.ctr == 0) ? 0 : e.ctr - 1;
            end
        end else if (tk) begin
            np = 1'b1;
            ne = '{tag: tag_of(pc), target: tgt, ctr: 2};
        end
    endfunction

    // One clock: drive, check lookup against the model, clock, advance the model.
    task automatic cycle(input bit rst, input logic [31:0] lk, input bit uv,
                         input logic [31:0] upc, input logic [31:0] tgt, input bit tk);
        bit          present, np;
        ent_t        e, ne;
        bit          ep;
        logic [31:0] ea;
        int          li, ui;
        reset                 = rst;
        bus.lookup_pc         = lk;
        bus.update_valid      = uv;
        bus.update_pc         = upc;
        bus.update_target     = tgt;
        bus.update_taken      = tk;
        #1;
        li      = idx_of(lk);
        present = mdl.exists(li);
        e       = present ? mdl[li] : '{tag: 0, target: 0, ctr: 0};
`ifdef BTB_BYPASS_EN
        if (uv && !rst && idx_of(upc) == li) begin
            m_next(present, e, upc, tgt, tk, np, ne);
            present = np;
            e       = ne;
        end
`endif
        ep = m_pred(present, e, lk);
        ea = ep ? e.target : 32'h0;
        check("pred", {31'b0, bus.btb_predicted}, {31'b0, ep});
        check("addr", bus.btb_predicted_address, ea);
        @(posedge clk);
        if (rst) begin
            mdl.delete();
        end else if (uv) begin
            ui      = idx_of(upc);
            present = mdl.exists(ui);
            e       = present ? mdl[ui] : '{tag: 0, target: 0, ctr: 0};
            m_next(present, e, upc, tgt, tk, np, ne);
            if (np) mdl[ui] = ne;
        end
        #1;
        reset            = 1'b0;
        bus.update_valid = 1'b0;
    endtask

    // Combinational peek with hand-derived expectations; no clock.
    task automatic look(input string tag, input logic [31:0] pc, input bit ep,
                        input logic [31:0] ea);
        bus.lookup_pc    = pc;
        bus.update_valid = 1'b0;
        #1;
        check({tag, "_pred"}, {31'b0, bus.btb_predicted}, {31'b0, ep});
        check({tag, "_addr"}, bus.btb_predicted_address, ea);
    endtask

    function automatic logic [31:0] rand_pc();
        if ($urandom_range(0, 7) == 0) return $urandom;
        return 32'($urandom_range(0, 3) * 4 * N + $urandom_range(0, N - 1) * 4
                   + $urandom_range(0, 3));
    endfunction

    initial begin
        reset             = 1'b1;
        bus.lookup_pc     = 32'h40;
        bus.update_valid  = 1'b0;
        bus.update_pc     = 32'h0;
        bus.update_target = 32'h0;
        bus.update_taken  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        look("rst_hold", 32'h40, 1'b0, 32'h0);
        reset = 1'b0;
        look("rst_state", 32'h40, 1'b0, 32'h0);

        // Concurrent lookup with the allocating update.
        cycle(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1);
        look("alloc", 32'h40, 1'b1, 32'h100);
        cycle(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b0);
        look("nt1", 32'h40, 1'b0, 32'h0);
        cycle(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b0);
        look("nt2", 32'h40, 1'b0, 32'h0);
        cycle(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1);
        look("t_from0", 32'h40, 1'b0, 32'h0);
        cycle(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1);
        look("t_to2", 32'h40, 1'b1, 32'h100);

        cycle(1'b0, 32'h40, 1'b1, 32'h80, 32'h200, 1'b1);
        look("alias_old", 32'h40, 1'b0, 32'h0);
        look("alias_new", 32'h80, 1'b1, 32'h200);
        cycle(1'b0, 32'h80, 1'b1, 32'hC0, 32'h300, 1'b0);
        look("nt_miss_keep", 32'h80, 1'b1, 32'h200);
        look("nt_miss_noalloc", 32'hC0, 1'b0, 32'h0);

        cycle(1'b0, 32'h40, 1'b1, 32'h40, 32'h100, 1'b1);
        cycle(1'b1, 32'h40, 1'b1, 32'h80, 32'h400, 1'b1);
        look("rst_clr40", 32'h40, 1'b0, 32'h0);
        look("rst_clr80", 32'h80, 1'b0, 32'h0);

        cycle(1'b0, 32'h0, 1'b1, 32'h43, 32'h500, 1'b1);
        look("lowbits", 32'h41, 1'b1, 32'h500);

        for (int i = 0; i < 600; i++) begin
            cycle($urandom_range(0, 59) == 0, rand_pc(), $urandom_range(0, 3) != 0,
                  rand_pc(), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/btb.md
BTB -- requirements
Module: btb

Interface
REQ-001 SHALL provide parameter ENTRIES, default 16, number of direct-mapped entries; power of two, 2..256.
REQ-002 SHALL derive IDX_W = log2(ENTRIES); index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2].
REQ-003 SHALL have port Clk  input  1  rising-edge clock.
REQ-004 SHALL have port Reset  input  1  reset; synchronous to Clk, active-high.
REQ-005 SHALL have port lookup_pc  input  32  fetch-stage PC being predicted.
REQ-006 SHALL have port btb_predicted  output  1  predict taken for lookup_pc.
REQ-007 SHALL have port btb_predicted_address  output  32  predicted target.
REQ-008 SHALL have port update_valid  input  1  resolved control-flow instruction this cycle.
REQ-009 SHALL have port update_pc  input  32  PC of resolved instruction.
REQ-010 SHALL have port update_target  input  32  resolved target address.
REQ-011 SHALL have port update_taken  input  1  resolved direction, 1 = taken.

Function
REQ-012 SHALL hold per entry: valid bit, tag, 32-bit target, 2-bit saturating counter (0 SNT, 1 WNT, 2 WT, 3 ST).
REQ-013 SHALL perform lookup combinationally, zero-cycle latency: hit = valid[idx] && tag[idx] == lookup_pc tag.
REQ-014 SHALL drive btb_predicted = hit && counter[idx][1].
REQ-015 SHALL drive btb_predicted_address = target[idx] when btb_predicted = 1, else 32'h0.
REQ-016 SHALL perform all updates on the rising Clk edge when update_valid = 1; no update when update_valid = 0.
REQ-017 Update hit, taken: counter saturating +1 (3 stays 3); target <= update_target.
REQ-018 Update hit, not taken: counter saturating -1 (0 stays 0); target unchanged; valid stays 1.
REQ-019 Update miss, taken: allocate/replace entry: valid <= 1, tag, target <= update_target, counter <= 2.
REQ-020 Update miss, not taken: no state change (no allocation, no eviction).
REQ-021 Same-index lookup and update in one cycle: lookup returns pre-update contents unless BTB_BYPASS_EN (REQ-026).
REQ-022 Tag aliasing: differing tags at same index SHALL replace only on taken miss (REQ-019).
REQ-023 update_pc[1:0] and lookup_pc[1:0] SHALL be ignored.

Reset
REQ-024 Reset = 1 at a Clk edge SHALL clear all valid bits and set all counters to 1 (WNT); tag/target contents undefined.
REQ-025 update_valid SHALL be ignored in any cycle with Reset = 1; while Reset is held, btb_predicted = 0 and btb_predicted_address = 32'h0 from the first edge onward.

Configuration
REQ-026 Macro BTB_BYPASS_EN: when defined, an update writing the looked-up index in the same cycle SHALL forward its post-update valid/tag/target/counter to the lookup outputs combinationally; when undefined, no forwarding, new state visible the cycle after the edge.

Verification
REQ-027 Reset, then lookup_pc=0x40 -> btb_predicted=0, btb_predicted_address=0x0.
REQ-028 Update pc=0x40 target=0x100 taken; next cycle lookup 0x40 -> btb_predicted=1, address=0x100 (counter 2).
REQ-029 From REQ-028, two not-taken updates at 0x40 -> after first, predicted=0 (counter 1); after second, counter 0; one taken update -> counter 1, still predicted=0.
REQ-030 Entry 0x40 valid, ENTRIES=16; taken update pc=0x80 target=0x200 (same index) -> lookup 0x40 predicted=0, lookup 0x80 predicted=1 address=0x200; not-taken update at 0xC0 leaves 0x80 intact.
REQ-031 Lookup 0x40 concurrent with first taken update 0x40->0x100: without BTB_BYPASS_EN predicted=0 that cycle, 1 next; with it predicted=1 address=0x100 same cycle.
REQ-032 Populate 0x40, assert Reset together with update_valid for 0x80 taken -> after Reset, both 0x40 and 0x80 lookups predicted=0.
